key_sched_ctrl: RTL and testbench



---
 rtl/key_sched_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_key_sched_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/key_sched_ctrl.sv
// Sequential AES key-schedule controller: expands NK key words into 4*(NR+1)
// words at one word per clock, then serves 128-bit round keys on request.
module key_sched_ctrl #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NK*32-1:0]  key,
  output logic              busy,
  output logic              done,
  output logic              keys_valid,
  input  logic              rk_req,
  input  logic [3:0]        rk_round,
  output logic              rk_valid,
  output logic [127:0]      rk_data,
  output logic              rk_err
);

  localparam int         NW      = 4 * (NR + 1);
  localparam logic [5:0] NK_W    = 6'(NK);
  localparam logic [5:0] LAST_W  = 6'(NW - 1);
  localparam logic [3:0] NR_W    = 4'(NR);
  localparam logic [2:0] POS_MAX = 3'(NK - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int n = 0; n < 8; n++) begin
      if (bb[0]) begin
        p = p ^ aa;
      end
      aa = xtime(aa);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int n = 0; n < 7; n++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  state_t       state_r, state_s;
  logic [5:0]   i_r, i_s;
  logic [2:0]   pos_r, pos_s;
  logic [7:0]   rcon_r, rcon_s;
  logic         busy_r, busy_s;
  logic         done_r, done_s;
  logic         keys_valid_r, keys_valid_s;
  logic         rk_valid_r, rk_valid_s;
  logic         rk_err_r, rk_err_s;
  logic [127:0] rk_data_r, rk_data_s;
  logic         load_key_s;
  logic         wr_en_s;
  logic [31:0]  w_r [NW];
  logic [31:0]  prev_s, old_s, sub_in_s, sub_out_s, temp_s, new_word_s;
  logic [5:0]   rd_base_s;

  // Next expanded word; one shared SubWord path serves both substitution cases
  always_comb begin
    prev_s    = w_r[i_r - 6'd1];
    old_s     = w_r[i_r - NK_W];
    sub_in_s  = (pos_r == 3'd0) ? rot_word(prev_s) : prev_s;
    sub_out_s = sub_word(sub_in_s);
    if (pos_r == 3'd0) begin
      temp_s = sub_out_s ^ {rcon_r, 24'h000000};
    end else if ((NK == 8) && (pos_r == 3'd4)) begin
      temp_s = sub_out_s;
    end else begin
      temp_s = prev_s;
    end
    new_word_s = old_s ^ temp_s;
  end

  // Control FSM next state, expansion counters and round-key read response
  always_comb begin
    state_s      = state_r;
    i_s          = i_r;
    pos_s        = pos_r;
    rcon_s       = rcon_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    keys_valid_s = keys_valid_r;
    rk_valid_s   = 1'b0;
    rk_err_s     = 1'b0;
    rk_data_s    = rk_data_r;
    load_key_s   = 1'b0;
    wr_en_s      = 1'b0;
    rd_base_s    = {rk_round, 2'b00};
    case (state_r)
      IDLE, READY: begin
        if (start) begin
          state_s      = EXPAND;
          i_s          = NK_W;
          pos_s        = 3'd0;
          rcon_s       = 8'h01;
          keys_valid_s = 1'b0;
          busy_s       = 1'b1;
          load_key_s   = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      EXPAND: begin
        wr_en_s = 1'b1;
        i_s     = i_r + 6'd1;
        pos_s   = (pos_r == POS_MAX) ? 3'd0 : pos_r + 3'd1;
        rcon_s  = (pos_r == 3'd0) ? xtime(rcon_r) : rcon_r;
        if (i_r == LAST_W) begin
          state_s      = READY;
          busy_s       = 1'b0;
          keys_valid_s = 1'b1;
          done_s       = 1'b1;
        end else begin
          state_s = EXPAND;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // A start accepted on the same edge invalidates the store, so it rejects the read
    if (rk_req) begin
      if ((state_r == READY) && !start && (rk_round <= NR_W)) begin
        rk_valid_s = 1'b1;
        rk_data_s  = {w_r[rd_base_s], w_r[rd_base_s + 6'd1],
                      w_r[rd_base_s + 6'd2], w_r[rd_base_s + 6'd3]};
      end else begin
        rk_err_s = 1'b1;
      end
    end else begin
      rk_err_s = 1'b0;
    end
  end

  // State and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      i_r          <= 6'd0;
      pos_r        <= 3'd0;
      rcon_r       <= 8'h01;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      keys_valid_r <= 1'b0;
      rk_valid_r   <= 1'b0;
      rk_err_r     <= 1'b0;
      rk_data_r    <= 128'd0;
    end else begin
      state_r      <= state_s;
      i_r          <= i_s;
      pos_r        <= pos_s;
      rcon_r       <= rcon_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      keys_valid_r <= keys_valid_s;
      rk_valid_r   <= rk_valid_s;
      rk_err_r     <= rk_err_s;
      rk_data_r    <= rk_data_s;
    end
  end

  // Round-key word store; contents are meaningless until keys_valid
  always_ff @(posedge clk) begin
    if (load_key_s) begin
      for (int k = 0; k < NK; k++) begin
        w_r[k] <= key[(NK - k) * 32 - 1 -: 32];
      end
    end else if (wr_en_s) begin
      w_r[i_r] <= new_word_s;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign keys_valid = keys_valid_r;
  assign rk_valid   = rk_valid_r;
  assign rk_err     = rk_err_r;
  assign rk_data    = rk_data_r;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl: AES-128/192/256 schedules against FIPS-197
// vectors plus protocol-error, restart and mid-expansion reset cases.
module tb_key_sched_ctrl;

  localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KBAD  = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] K0F   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] R1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R10B  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] R12   = 128'ha4970a331a78dc09c418c271e3a41d5d;
  localparam logic [127:0] R14   = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, rk_req;
  logic [3:0]   rk_round;
  logic         st128, st192, st256;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic         busy128, done128, kv128, val128, err128;
  logic         busy192, done192, kv192, val192, err192;
  logic         busy256, done256, kv256, val256, err256;
  logic [127:0] data128, data192, data256;
  logic [4:0]   f;
  int           total, passed;

  key_sched_ctrl #(.NK(4), .NR(10)) u128 (
    .clk(clk), .reset(reset), .start(st128), .key(key128), .busy(busy128), .done(done128),
    .keys_valid(kv128), .rk_req(rk_req), .rk_round(rk_round), .rk_valid(val128),
    .rk_data(data128), .rk_err(err128));

  key_sched_ctrl #(.NK(6), .NR(12)) u192 (
    .clk(clk), .reset(reset), .start(st192), .key(key192), .busy(busy192), .done(done192),
    .keys_valid(kv192), .rk_req(rk_req), .rk_round(rk_round), .rk_valid(val192),
    .rk_data(data192), .rk_err(err192));

  key_sched_ctrl #(.NK(8), .NR(14)) u256 (
    .clk(clk), .reset(reset), .start(st256), .key(key256), .busy(busy256), .done(done256),
    .keys_valid(kv256), .rk_req(rk_req), .rk_round(rk_round), .rk_valid(val256),
    .rk_data(data256), .rk_err(err256));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {busy, done, keys_valid, rk_valid, rk_err} of the selected instance
  function automatic logic [4:0] flags(input int sel);
    case (sel)
      0:       return {busy128, done128, kv128, val128, err128};
      1:       return {busy192, done192, kv192, val192, err192};
      default: return {busy256, done256, kv256, val256, err256};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] r);
    rk_req   = 1'b1;
    rk_round = r;
    tick();
    rk_req   = 1'b0;
  endtask

  // Start an expansion, optionally inject a read (req_at) or a second start
  // (restart_at, AES-128 only) at a given busy cycle, and check the timing
  task automatic expand(input int sel, input logic [255:0] k, input int exp_busy,
                        input int req_at, input int restart_at, input string tag);
    int cnt;
    logic [4:0] g;
    cnt = 0;
    case (sel)
      0:       begin key128 = k[127:0]; st128 = 1'b1; end
      1:       begin key192 = k[191:0]; st192 = 1'b1; end
      default: begin key256 = k;        st256 = 1'b1; end
    endcase
    rk_req   = (req_at == 0);
    rk_round = 4'd0;
    tick();
    st128 = 1'b0;
    st192 = 1'b0;
    st256 = 1'b0;
    rk_req = 1'b0;
    g = flags(sel);
    check({tag, "_kv_clear"}, 128'(g[2]), 128'd0);
    if (req_at == 0) check({tag, "_req_on_start"}, 128'(g[1:0]), 128'd1);
    while (g[4] && cnt < 200) begin
      cnt++;
      rk_req   = (cnt == req_at);
      rk_round = 4'd1;
      if (cnt == restart_at) begin
        st128  = 1'b1;
        key128 = KBAD;
      end
      tick();
      st128  = 1'b0;
      rk_req = 1'b0;
      g = flags(sel);
      if (cnt == req_at) check({tag, "_req_in_expand"}, 128'(g[1:0]), 128'd1);
    end
    check({tag, "_busy_cycles"}, 128'(cnt), 128'(exp_busy));
    check({tag, "_done_cycle"}, 128'(g[4:2]), 128'd3);
    tick();
    g = flags(sel);
    check({tag, "_done_pulse"}, 128'(g[4:2]), 128'd1);
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    reset    = 1'b1;
    rk_req   = 1'b0;
    rk_round = 4'd0;
    st128    = 1'b0;
    st192    = 1'b0;
    st256    = 1'b0;
    key128   = '0;
    key192   = '0;
    key256   = '0;
    tick();
    tick();
    check("reset_flags", 128'(flags(0)), 128'd0);
    check("reset_data", data128, 128'd0);
    reset = 1'b0;

    rd(4'd1);
    f = flags(0);
    check("idle_req_err", 128'(f[1:0]), 128'd1);

    expand(0, 256'(K1), 40, 5, 10, "aes128");

    // back-to-back reads, then an out-of-range round
    rk_req = 1'b1;
    rk_round = 4'd1;
    tick();
    f = flags(0);
    check("rk1_valid", 128'(f[1:0]), 128'd2);
    check("rk1_data", data128, R1);
    rk_round = 4'd10;
    tick();
    check("rk10_data", data128, R10);
    rk_round = 4'd0;
    tick();
    check("rk0_data", data128, K1);
    rk_round = 4'd11;
    tick();
    f = flags(0);
    check("rk11_err", 128'(f[1:0]), 128'd1);
    check("rk11_hold", data128, K1);
    rk_req = 1'b0;
    tick();
    f = flags(0);
    check("rk_idle_no_pulse", 128'(f[1:0]), 128'd0);

    expand(0, 256'(K0F), 40, 0, -1, "restart");
    rd(4'd10);
    check("restart_rk10", data128, R10B);

    // reset during expansion
    key128 = K1;
    st128  = 1'b1;
    tick();
    st128 = 1'b0;
    repeat (19) tick();
    f = flags(0);
    check("mid_expand_busy", 128'(f[4]), 128'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset_flags", 128'(flags(0)), 128'd0);
    check("mid_reset_data", data128, 128'd0);
    rd(4'd10);
    f = flags(0);
    check("post_reset_req_err", 128'(f[1:0]), 128'd1);
    expand(0, 256'(K1), 40, 40, -1, "post_reset");
    rd(4'd10);
    check("post_reset_rk10", data128, R10);

    expand(1, 256'(K192), 46, -1, -1, "aes192");
    rd(4'd12);
    check("aes192_rk12", data192, R12);
    check("aes192_valid", 128'(val192), 128'd1);

    expand(2, K256, 52, -1, -1, "aes256");
    rd(4'd14);
    check("aes256_rk14", data256, R14);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
